// File: rtl/stripe_write_scheduler_if.sv
// Lane handshakes, parity-calculator issue bus and status lines of the stripe write scheduler.
interface stripe_write_scheduler_if;
  logic        d0_valid;
  logic        d0_ready;
  logic [11:0] d0_data;
  logic [7:0]  d0_addr;
  logic        d1_valid;
  logic        d1_ready;
  logic [11:0] d1_data;
  logic [7:0]  d1_addr;
  logic        pc_enable;
  logic [11:0] pc_d0;
  logic [11:0] pc_d1;
  logic [7:0]  pc_addr;
  logic        wr_credit_return;
  logic        mismatch_err;
  logic        credit_err;
  logic        busy;

  modport master (
    output d0_valid, d0_data, d0_addr,
    output d1_valid, d1_data, d1_addr,
    output wr_credit_return,
    input  d0_ready, d1_ready,
    input  pc_enable, pc_d0, pc_d1, pc_addr,
    input  mismatch_err, credit_err, busy
  );

  modport slave (
    input  d0_valid, d0_data, d0_addr,
    input  d1_valid, d1_data, d1_addr,
    input  wr_credit_return,
    output d0_ready, d1_ready,
    output pc_enable, pc_d0, pc_d1, pc_addr,
    output mismatch_err, credit_err, busy
  );
endinterface

// File: rtl/stripe_write_scheduler.sv
// Pairs words from two lane FIFOs by stripe address and issues credit-throttled strobes to the parity calculator.
// Define STRIPE_DEGRADED_WRITE_EN to issue a lone head with the missing lane zeroed after TIMEOUT idle cycles.
module stripe_write_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int CREDITS    = 2,
  parameter int TIMEOUT    = 15
) (
  input logic                     clk,
  input logic                     reset_n,
  stripe_write_scheduler_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT_PEER, DEGRADED} state_t;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two of at least 2");
  end
  if (CREDITS < 1 || CREDITS > 15) begin : g_bad_credits
    $error("CREDITS must lie in 1..15");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must lie in 1..255");
  end

  state_t        state;
  state_t        state_next;
  logic [19:0]   mem [2][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr [2];
  logic [AW-1:0] rd_ptr [2];
  logic [CW-1:0] count [2];
  logic [19:0]   din [2];
  logic [7:0]    head_addr [2];
  logic [11:0]   head_data [2];
  logic [1:0]    valid;
  logic [1:0]    ready;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic [1:0]    head_valid;
  logic [3:0]    credits;
  logic          issue;
  logic          drop;
  logic [11:0]   issue_d0;
  logic [11:0]   issue_d1;
  logic [7:0]    issue_addr;
  logic          pc_enable;
  logic [11:0]   pc_d0;
  logic [11:0]   pc_d1;
  logic [7:0]    pc_addr;
  logic          mismatch_err;
  logic          credit_err;
`ifdef STRIPE_DEGRADED_WRITE_EN
  logic [7:0]    timer;
`endif

  assign valid = {bus.d1_valid, bus.d0_valid};
  assign din[0] = {bus.d0_addr, bus.d0_data};
  assign din[1] = {bus.d1_addr, bus.d1_data};

  assign bus.d0_ready     = ready[0];
  assign bus.d1_ready     = ready[1];
  assign bus.pc_enable    = pc_enable;
  assign bus.pc_d0        = pc_d0;
  assign bus.pc_d1        = pc_d1;
  assign bus.pc_addr      = pc_addr;
  assign bus.mismatch_err = mismatch_err;
  assign bus.credit_err   = credit_err;
  assign bus.busy         = (|head_valid) || (state != IDLE);

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ready[i]      = reset_n && (count[i] != CW'(FIFO_DEPTH));
      push[i]       = valid[i] && ready[i];
      head_valid[i] = (count[i] != '0);
      head_addr[i]  = mem[i][rd_ptr[i]][19:12];
      head_data[i]  = mem[i][rd_ptr[i]][11:0];
    end
  end

  // Storage carries no reset: an empty FIFO never exposes its stale contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= din[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
        else if (!push[i] && pop[i]) count[i] <= count[i] - 1'b1;
      end
    end
  end

  // A pair of valid heads is always resolved first, whatever the state; the FSM only handles lone heads.
  always_comb begin
    state_next = state;
    pop        = '0;
    issue      = 1'b0;
    drop       = 1'b0;
    issue_d0   = '0;
    issue_d1   = '0;
    issue_addr = '0;
    if (&head_valid) begin
      state_next = IDLE;
      if (head_addr[0] == head_addr[1]) begin
        if (credits != '0) begin
          issue      = 1'b1;
          pop        = 2'b11;
          issue_d0   = head_data[0];
          issue_d1   = head_data[1];
          issue_addr = head_addr[0];
        end
      end else begin
        drop = 1'b1;
        pop  = (head_addr[0] < head_addr[1]) ? 2'b01 : 2'b10;
      end
    end else begin
      case (state)
        IDLE: begin
          if (|head_valid) state_next = WAIT_PEER;
        end
        WAIT_PEER: begin
          if (!(|head_valid)) state_next = IDLE;
`ifdef STRIPE_DEGRADED_WRITE_EN
          else if (timer == 8'(TIMEOUT) && credits != '0) state_next = DEGRADED;
`endif
        end
        DEGRADED: begin
`ifdef STRIPE_DEGRADED_WRITE_EN
          if (!(|head_valid)) begin
            state_next = IDLE;
          end else if (credits != '0) begin
            state_next = IDLE;
            issue      = 1'b1;
            if (head_valid[0]) begin
              pop        = 2'b01;
              issue_d0   = head_data[0];
              issue_addr = head_addr[0];
            end else begin
              pop        = 2'b10;
              issue_d1   = head_data[1];
              issue_addr = head_addr[1];
            end
          end
`else
          state_next = IDLE;
`endif
        end
        default: state_next = IDLE;
      endcase
    end
  end

`ifdef STRIPE_DEGRADED_WRITE_EN
  // Saturates at TIMEOUT so a credit-starved timeout is remembered until a slot frees up.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer <= '0;
    end else if (state != WAIT_PEER) begin
      timer <= '0;
    end else if (timer != 8'(TIMEOUT)) begin
      timer <= timer + 8'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      credits      <= 4'(CREDITS);
      credit_err   <= 1'b0;
      pc_enable    <= 1'b0;
      pc_d0        <= '0;
      pc_d1        <= '0;
      pc_addr      <= '0;
      mismatch_err <= 1'b0;
    end else begin
      state        <= state_next;
      pc_enable    <= issue;
      pc_d0        <= issue_d0;
      pc_d1        <= issue_d1;
      pc_addr      <= issue_addr;
      mismatch_err <= drop;
      if (issue && !bus.wr_credit_return) begin
        credits <= credits - 4'd1;
      end else if (!issue && bus.wr_credit_return) begin
        if (credits == 4'(CREDITS)) credit_err <= 1'b1;
        else                        credits    <= credits + 4'd1;
      end
    end
  end

endmodule
